// File: rtl/lc3_mmio_pkg.sv
// lc3_mmio_pkg: register map, status bit positions and channel status type shared by the MMIO controller.
package lc3_mmio_pkg;
    localparam logic [2:0] OFF_RSR = 3'd0;
    localparam logic [2:0] OFF_RDR = 3'd2;
    localparam logic [2:0] OFF_TSR = 3'd4;
    localparam logic [2:0] OFF_TDR = 3'd6;
    localparam int READY = 15;
    localparam int IE = 14;
    localparam int OVR = 13;
    localparam int CH_STRIDE = 8;
    typedef struct packed {
        logic rie;
        logic tie;
        logic ovr;
        logic tx_rdy;
    } ch_status_t;
endpackage

// File: rtl/lc3_mmio_fifo.sv
// lc3_mmio_fifo: power-of-2 synchronous FIFO; callers never push when full or pop when empty.
module lc3_mmio_fifo #(
    parameter int W = 16,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic [W-1:0]               wdata,
    output logic [W-1:0]               rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);
    logic [W-1:0] mem [DEPTH];
    logic [AW-1:0] wp, rp;
    always_ff @(posedge clk) begin
        if (push) mem[wp] <= wdata;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp <= '0;
            rp <= '0;
            count <= '0;
        end else begin
            if (push) wp <= wp + 1'b1;
            if (pop) rp <= rp + 1'b1;
            count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
        end
    end
    assign rdata = mem[rp];
    assign full = count == (AW + 1)'(DEPTH);
    assign empty = count == '0;
endmodule

// File: rtl/lc3_mmio_ctrl.sv
// lc3_mmio_ctrl: NUM_CH-channel memory-mapped I/O for the LC-3 with buffered receive,
// one-entry transmit holding registers and a registered, prioritised interrupt request.
module lc3_mmio_ctrl
    import lc3_mmio_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16,
    parameter int NUM_CH = 2,
    parameter int FIFO_DEPTH = 4,
    parameter logic [ADDR_W-1:0] BASE_ADDR = 16'hFE00,
    parameter logic [2:0] INT_PRI = 3'd4,
    parameter logic [7:0] VEC_BASE = 8'h80
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [ADDR_W-1:0]          addr,
    input  logic [DATA_W-1:0]          wdata,
    input  logic                       rd_en,
    input  logic                       wr_en,
    output logic                       hit,
    output logic [DATA_W-1:0]          rdata,
    input  logic [NUM_CH-1:0]          rx_valid,
    input  logic [NUM_CH*DATA_W-1:0]   rx_data,
    output logic [NUM_CH-1:0]          rx_ready,
    output logic [NUM_CH-1:0]          tx_valid,
    output logic [NUM_CH*DATA_W-1:0]   tx_data,
    input  logic [NUM_CH-1:0]          tx_ready,
    output logic                       irq,
    output logic [2:0]                 irq_pri,
    output logic [7:0]                 irq_vec
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    logic [ADDR_W-1:0] rel;
    logic [2:0] off, ch_sel;
    logic [NUM_CH-1:0] rx_empty, rx_full, rx_src, tx_src;
    logic [NUM_CH-1:0][DATA_W-1:0] rsr_w, rdr_w, tsr_w;
    logic src;
    logic [7:0] vec_n;
    assign rel = addr - BASE_ADDR;
    assign off = rel[2:0];
    assign ch_sel = rel[5:3];
    assign hit = (addr >= BASE_ADDR) && (rel < ADDR_W'(CH_STRIDE * NUM_CH)) && !off[0];
    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic sel, pop, wr_rsr, wr_tsr, wr_tdr;
        logic [DATA_W-1:0] head, txd, rsr, tsr;
        logic [CW-1:0] cnt;
        ch_status_t s;
        assign sel = hit && ch_sel == 3'(c);
        assign pop = sel && rd_en && off == OFF_RDR && !rx_empty[c];
        assign wr_rsr = sel && wr_en && off == OFF_RSR;
        assign wr_tsr = sel && wr_en && off == OFF_TSR;
        assign wr_tdr = sel && wr_en && off == OFF_TDR;
        assign rx_ready[c] = !rx_full[c];
        lc3_mmio_fifo #(.W(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
            .clk(clk),
            .rst(rst),
            .push(rx_valid[c] && !rx_full[c]),
            .pop(pop),
            .wdata(rx_data[c*DATA_W +: DATA_W]),
            .rdata(head),
            .full(rx_full[c]),
            .empty(rx_empty[c]),
            .count(cnt)
        );
        // A TDR write is judged against the ready bit before any same-cycle handshake.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                s <= '{rie: 1'b0, tie: 1'b0, ovr: 1'b0, tx_rdy: 1'b1};
                txd <= '0;
            end else begin
                if (wr_rsr) s.rie <= wdata[IE];
                if (wr_tsr) s.tie <= wdata[IE];
                if (wr_tsr) s.ovr <= 1'b0;
                else if (wr_tdr && !s.tx_rdy) s.ovr <= 1'b1;
                if (wr_tdr && s.tx_rdy) begin
                    txd <= wdata;
                    s.tx_rdy <= 1'b0;
                end else if (tx_valid[c] && tx_ready[c]) s.tx_rdy <= 1'b1;
            end
        end
        always_comb begin
            rsr = '0;
            rsr[READY] = !rx_empty[c];
            rsr[IE] = s.rie;
            rsr[3:0] = 4'(cnt);
            tsr = '0;
            tsr[READY] = s.tx_rdy;
            tsr[IE] = s.tie;
            tsr[OVR] = s.ovr;
        end
        assign rsr_w[c] = rsr;
        assign tsr_w[c] = tsr;
        assign rdr_w[c] = rx_empty[c] ? '0 : head;
        assign tx_valid[c] = !s.tx_rdy;
        assign tx_data[c*DATA_W +: DATA_W] = txd;
        assign rx_src[c] = s.rie && !rx_empty[c];
        assign tx_src[c] = s.tie && s.tx_rdy;
    end
    always_comb begin
        rdata = '0;
        for (int i = 0; i < NUM_CH; i++)
            if (rd_en && hit && ch_sel == 3'(i))
                rdata = off == OFF_RSR ? rsr_w[i] : off == OFF_RDR ? rdr_w[i] :
                        off == OFF_TSR ? tsr_w[i] : '0;
    end
    // Scan from the lowest-priority source upward so the highest-priority one wins.
    always_comb begin
        src = 1'b0;
        vec_n = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (tx_src[i]) begin
                src = 1'b1;
                vec_n = VEC_BASE + 8'(2 * i + 1);
            end
            if (rx_src[i]) begin
                src = 1'b1;
                vec_n = VEC_BASE + 8'(2 * i);
            end
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            irq <= 1'b0;
            irq_pri <= '0;
            irq_vec <= '0;
        end else begin
            irq <= src;
            irq_pri <= src ? INT_PRI : 3'd0;
            irq_vec <= src ? vec_n : 8'd0;
        end
    end
    assert property (@(posedge clk) disable iff (rst) !(rd_en && wr_en));
endmodule
